// File: rtl/aes128_wb_pkg.sv
// Shared constants and helpers for the aes128 Wishbone register block.
package aes128_wb_pkg;

  localparam int unsigned DEFAULT_LATENCY = 21;

  localparam logic [7:0] OFS_KEY0   = 8'h00;
  localparam logic [7:0] OFS_ST0    = 8'h10;
  localparam logic [7:0] OFS_OUT0   = 8'h20;
  localparam logic [7:0] OFS_CTRL   = 8'h30;
  localparam logic [7:0] OFS_STATUS = 8'h34;

  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } op_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes128_wb_regs.sv
// Wishbone classic register window around the aes128 core.
module aes128_wb_regs
  import aes128_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] aes_key,
  output logic [127:0] aes_state,
  input  logic [127:0] aes_out,
  output logic         irq
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  localparam logic [3:0] GRP_KEY  = OFS_KEY0[7:4];
  localparam logic [3:0] GRP_ST   = OFS_ST0[7:4];
  localparam logic [3:0] GRP_OUT  = OFS_OUT0[7:4];
  localparam logic [3:0] GRP_CSR  = OFS_CTRL[7:4];
  localparam logic [5:0] W_CTRL   = OFS_CTRL[7:2];
  localparam logic [5:0] W_STATUS = OFS_STATUS[7:2];

  op_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0][31:0] key_q, key_d;
  logic [3:0][31:0] st_q, st_d;
  logic [3:0][31:0] out_q, out_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  logic [31:0]      rdata;
  logic             req, busy, start, w1c;
  logic [5:0]       word;
  logic [3:0]       grp;
  logic [1:0]       idx;
  logic [1:0]       unused_adr;

  assign unused_adr = wbs_adr_i[1:0];
  assign word       = wbs_adr_i[7:2];
  assign grp        = word[5:2];
  assign idx        = word[1:0];
  assign busy       = (state_q == ST_BUSY);
  assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q
                    & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  always_comb begin
    rdata = '0;
    case (grp)
      GRP_KEY: rdata = key_q[idx];
      GRP_ST:  rdata = st_q[idx];
      GRP_OUT: rdata = out_q[idx];
      GRP_CSR: begin
        if (word == W_CTRL) begin
          rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (word == W_STATUS) begin
          rdata[STATUS_BUSY_BIT] = busy;
          rdata[STATUS_DONE_BIT] = done_q;
        end
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    st_d     = st_q;
    out_d    = out_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    ack_d    = req;
    dat_d    = '0;
    irq_d    = done_q & irq_en_q;
    start    = 1'b0;
    w1c      = 1'b0;

    if (req && !wbs_we_i) dat_d = rdata;

    if (req && wbs_we_i) begin
      if (grp == GRP_KEY) begin
        if (!busy) key_d[idx] = merge_bytes(key_q[idx], wbs_dat_i, wbs_sel_i);
      end else if (grp == GRP_ST) begin
        if (!busy) st_d[idx] = merge_bytes(st_q[idx], wbs_dat_i, wbs_sel_i);
      end else if (word == W_CTRL) begin
        if (wbs_sel_i[0]) begin
          irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
          start    = wbs_dat_i[CTRL_START_BIT] & ~busy;
        end
      end else if (word == W_STATUS) begin
        w1c = wbs_sel_i[0] & wbs_dat_i[STATUS_DONE_BIT];
      end
    end

    if (start || w1c) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          out_d[0] = aes_out[127:96];
          out_d[1] = aes_out[95:64];
          out_d[2] = aes_out[63:32];
          out_d[3] = aes_out[31:0];
          // completion overrides a W1C landing on the same edge
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      st_q     <= '0;
      out_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      st_q     <= st_d;
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;
  assign aes_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_state = {st_q[0], st_q[1], st_q[2], st_q[3]};

endmodule
